scytale_encryption: RTL and testbench

Scytale transposition encryptor. It is the transmit-side counterpart of the scytale decryption block, and its output stream decrypts with the same key_N/key_M.
- Buffers plaintext characters until START_ENCRYPTION_TOKEN arrives.
- Then streams the ciphertext out one character per clock with busy/valid_o framing, matching the decryptor's input interface.
- Encryption mapping for a message of length L: the matrix has key_M rows and key_N columns. For r = 0..key_M-1, for k = r, r+key_M, r+2·key_M, … while k < L, emit p[k].

---
 rtl/scytale_encryption.sv | 148 ++++++++++++++
 tb/tb_scytale_encryption.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/scytale_encryption.sv
// Scytale transposition encryptor: buffers plaintext until the start token, then
// streams the ciphertext row by row (stride key_M) with busy/valid_o framing.
module scytale_encryption #(
  parameter int                   D_WIDTH                = 8,
  parameter int                   KEY_WIDTH              = 8,
  parameter int                   MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0]   START_ENCRYPTION_TOKEN = 'hFA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key_N,
  input  logic [KEY_WIDTH-1:0] key_M,
  output logic                 busy,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o
);

  localparam int                   AW    = $clog2(MAX_NOF_CHARS);
  localparam logic [KEY_WIDTH-1:0] MAX_L = KEY_WIDTH'(MAX_NOF_CHARS);

  typedef enum logic [1:0] {S_IDLE, S_START, S_EMIT} state_e;

  state_e               state_q, state_d;
  logic [KEY_WIDTH-1:0] len_q, len_d;
  logic [KEY_WIDTH-1:0] m_q, m_d;
  logic [KEY_WIDTH-1:0] r_q, r_d;
  logic [KEY_WIDTH-1:0] k_q, k_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic [D_WIDTH-1:0]   data_q, data_d;
  logic [D_WIDTH-1:0]   buf_q [MAX_NOF_CHARS];
  logic [D_WIDTH-1:0]   buf_d [MAX_NOF_CHARS];

  // One extra bit on the index arithmetic so k+m and r+1 never wrap.
  logic [KEY_WIDTH:0] k_step, r_inc, len_w, m_w;
  logic               term;

  // The column count does not affect the output ordering.
  logic unused_key_n;
  assign unused_key_n = ^key_N;

  assign len_w  = {1'b0, len_q};
  assign m_w    = {1'b0, m_q};
  assign k_step = {1'b0, k_q} + m_w;
  assign r_inc  = {1'b0, r_q} + (KEY_WIDTH+1)'(1);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    len_d   = len_q;
    m_d     = m_q;
    r_d     = r_q;
    k_d     = k_q;
    done_d  = done_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    data_d  = '0;
    buf_d   = buf_q;
    term    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          if (data_i == START_ENCRYPTION_TOKEN) begin
            m_d     = key_M;
            r_d     = '0;
            k_d     = '0;
            done_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = S_START;
          end else if (len_q < MAX_L) begin
            buf_d[len_q[AW-1:0]] = data_i;
            len_d                = len_q + KEY_WIDTH'(1);
          end
        end
      end
      S_START: begin
        if (len_q == '0 || m_q == '0) term = 1'b1;
        else                          state_d = S_EMIT;
      end
      S_EMIT: begin
        if (done_q) begin
          term = 1'b1;
        end else begin
          valid_d = 1'b1;
          data_d  = buf_q[k_q[AW-1:0]];
          if (k_step < len_w) begin
            k_d = k_step[KEY_WIDTH-1:0];
          end else if (r_inc >= m_w || r_inc >= len_w) begin
            done_d = 1'b1;
          end else begin
            r_d = r_inc[KEY_WIDTH-1:0];
            k_d = r_inc[KEY_WIDTH-1:0];
          end
        end
      end
      default: term = 1'b1;
    endcase

    if (term) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      valid_d = 1'b0;
      data_d  = '0;
      len_d   = '0;
      r_d     = '0;
      k_d     = '0;
      done_d  = 1'b0;
      for (int i = 0; i < MAX_NOF_CHARS; i++) buf_d[i] = '0;
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      m_q     <= '0;
      r_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      // NOTE: the buffer is flop-based and cleared on reset so stale plaintext never leaks out.
      for (int i = 0; i < MAX_NOF_CHARS; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      m_q     <= m_d;
      r_q     <= r_d;
      k_q     <= k_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      buf_q   <= buf_d;
    end
  end

  assign busy    = busy_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_scytale_encryption.sv
// Self-checking bench for scytale_encryption: table of messages with expected
// ciphertext, a scoreboard queue checked by a monitor, plus reset/overflow sequences.
module tb_scytale_encryption;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_i;
  logic       valid_i;
  logic [7:0] key_N;
  logic [7:0] key_M;
  logic       busy;
  logic [7:0] data_o;
  logic       valid_o;

  scytale_encryption dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (data_i),
    .valid_i (valid_i),
    .key_N   (key_N),
    .key_M   (key_M),
    .busy    (busy),
    .data_o  (data_o),
    .valid_o (valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    string      txt;
    logic [7:0] m;
    string      exp;
    bit         noise;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  int         total = 0;
  int         bad   = 0;
  bit         mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every valid_o beat pops one expected character.
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_o) begin
        if (exp_q.size() == 0) check("unexpected valid_o", 32'd1, 32'd0);
        else                   check("data_o", {24'd0, data_o}, {24'd0, exp_q.pop_front()});
      end else begin
        check("data_o zero when idle", {24'd0, data_o}, 32'd0);
      end
    end
  end

  task automatic add_vec(input string name, input string txt, input logic [7:0] m,
                         input string exp, input bit noise);
    vec_t v;
    v.name = name; v.txt = txt; v.m = m; v.exp = exp; v.noise = noise;
    vecs.push_back(v);
  endtask

  task automatic send_chars(input string txt);
    for (int i = 0; i < txt.len(); i++) begin
      @(posedge clk); #1;
      valid_i = 1'b1;
      data_i  = txt[i];
    end
  endtask

  task automatic send_token(input logic [7:0] m);
    @(posedge clk); #1;
    valid_i = 1'b1;
    data_i  = 8'hFA;
    key_M   = m;
    key_N   = 8'($urandom_range(1, 9));
    @(posedge clk); #1;
    valid_i = 1'b0;
    data_i  = 8'h00;
    key_M   = 8'($urandom_range(0, 255));
  endtask

  task automatic run_msg(input string name, input string txt, input logic [7:0] m,
                         input string exp, input bit noise);
    int len, exp_busy, c, nvalid, first;
    len      = (txt.len() > 50) ? 50 : txt.len();
    exp_busy = (len == 0 || m == 0) ? 1 : len + 2;
    for (int i = 0; i < exp.len(); i++) exp_q.push_back(exp[i]);
    send_chars(txt);
    send_token(m);
    c = 0; nvalid = 0; first = -1;
    while (busy && c < 300) begin
      if (valid_o) begin
        nvalid++;
        if (first < 0) first = c;
      end
      if (noise) begin
        valid_i = c[0];
        data_i  = (c % 3 == 0) ? 8'hFA : 8'h5A;
      end
      @(posedge clk); #1;
      c++;
    end
    valid_i = 1'b0;
    data_i  = 8'h00;
    check({name, " busy cycles"}, c, exp_busy);
    check({name, " valid count"}, nvalid, exp.len());
    if (exp.len() > 0) check({name, " first valid offset"}, first, 2);
    check({name, " valid_o low at end"}, {31'd0, valid_o}, 32'd0);
    check({name, " data_o zero at end"}, {24'd0, data_o}, 32'd0);
    @(negedge clk);
    check({name, " scoreboard drained"}, exp_q.size(), 0);
  endtask

  initial begin
    string big, big_exp;

    rst_n   = 1'b0;
    valid_i = 1'b0;
    data_i  = 8'h00;
    key_N   = 8'd0;
    key_M   = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy",    {31'd0, busy},    32'd0);
    check("reset valid_o", {31'd0, valid_o}, 32'd0);
    check("reset data_o",  {24'd0, data_o},  32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    add_vec("m2 len8",        "ABCDEFGH", 8'd2, "ACEGBDFH", 1'b0);
    add_vec("m2 len6",        "ABCDEF",   8'd2, "ACEBDF",   1'b0);
    add_vec("m2 partial",     "ABCDE",    8'd2, "ACEBD",    1'b0);
    add_vec("empty msg",      "",         8'd2, "",         1'b0);
    add_vec("m3 len7",        "ABCDEFG",  8'd3, "ADGBECF",  1'b0);
    add_vec("m gt len",       "ABC",      8'd5, "ABC",      1'b0);
    add_vec("m zero",         "ABCDEF",   8'd0, "",         1'b0);
    add_vec("noise m1",       "HELLO",    8'd1, "HELLO",    1'b1);
    add_vec("noise m2",       "WXYZ",     8'd2, "WYXZ",     1'b1);
    add_vec("single char",    "Q",        8'd4, "Q",        1'b0);

    for (int i = 0; i < vecs.size(); i++)
      run_msg(vecs[i].name, vecs[i].txt, vecs[i].m, vecs[i].exp, vecs[i].noise);

    // Overflow: 52 characters, only the first 50 are kept.
    big = ""; big_exp = "";
    for (int i = 0; i < 52; i++) begin
      big = $sformatf("%s%c", big, 8'h30 + i);
      if (i < 50) big_exp = $sformatf("%s%c", big_exp, 8'h30 + i);
    end
    run_msg("overflow m1", big, 8'd1, big_exp, 1'b0);

    // Reset in the middle of emission: only the first two beats come out.
    exp_q.push_back("A");
    exp_q.push_back("C");
    send_chars("ABCDEFGH");
    send_token(8'd2);
    check("mid reset busy before", {31'd0, busy}, 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid reset busy",    {31'd0, busy},    32'd0);
    check("mid reset valid_o", {31'd0, valid_o}, 32'd0);
    check("mid reset data_o",  {24'd0, data_o},  32'd0);
    @(negedge clk);
    check("mid reset scoreboard", exp_q.size(), 0);
    exp_q.delete();
    run_msg("after reset", "AB", 8'd1, "AB", 1'b0);

    // Back-to-back: capture starts on the cycle busy falls.
    run_msg("back to back", "XYZ", 8'd2, "XZY", 1'b0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
